// File: rtl/memory_responder_if.sv
// One cache port of the memory request bus: request/response handshake plus
// the invalidate broadcast that memory sends back to that cache.
interface memory_responder_if;
  logic [24:0] memory_request;
  logic        memory_request_ready;
  logic [15:0] memory_response;
  logic        memory_response_ready;
  logic [15:0] invalidate_address;
  logic        invalidate_valid;

  modport master (
    output memory_request, memory_request_ready,
    input  memory_response, memory_response_ready, invalidate_address, invalidate_valid
  );

  modport slave (
    input  memory_request, memory_request_ready,
    output memory_response, memory_response_ready, invalidate_address, invalidate_valid
  );
endinterface

// File: rtl/memory_responder.sv
// Shared main-memory responder for two cache ports: round-robin arbitration,
// byte-merge writes into a 16-bit word store, and cross-port invalidates.
module memory_responder #(
  parameter int MEM_WORD_BITS = 15,
  parameter int LATENCY       = 2
) (
  input  logic                clock,
  input  logic                reset,
  memory_responder_if.slave   port_0,
  memory_responder_if.slave   port_1,
  output logic                busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [15:0] mem [0:(2**MEM_WORD_BITS)-1];

  logic [1:0]  state_r;
  logic [CW-1:0] count_r;
  logic        last_grant_r;
  logic        grant_r;
  logic        cmd_r;
  logic [7:0]  data_r;
  logic [15:0] addr_r;
  logic        armed_0_r;
  logic        armed_1_r;

  logic [15:0] response_0_r;
  logic        response_ready_0_r;
  logic [15:0] inv_address_0_r;
  logic        inv_valid_0_r;
  logic [15:0] response_1_r;
  logic        response_ready_1_r;
  logic [15:0] inv_address_1_r;
  logic        inv_valid_1_r;

  logic        eligible_0_s;
  logic        eligible_1_s;
  logic        next_grant_s;
  logic        capture_s;
  logic        do_access_s;
  logic [MEM_WORD_BITS-1:0] word_s;
  logic [15:0] old_word_s;
  logic [15:0] merged_s;
  logic [15:0] rdata_s;

  // Arbitration and the word/merge datapath for the pending access
  always_comb begin
    eligible_0_s = port_0.memory_request_ready & armed_0_r;
    eligible_1_s = port_1.memory_request_ready & armed_1_r;
    if (eligible_0_s && eligible_1_s) begin
      next_grant_s = ~last_grant_r;
    end else if (eligible_1_s) begin
      next_grant_s = 1'b1;
    end else begin
      next_grant_s = 1'b0;
    end
    capture_s   = (state_r == IDLE) && (eligible_0_s || eligible_1_s);
    do_access_s = (state_r == ACCESS) && (count_r == '0);
    word_s      = addr_r[MEM_WORD_BITS:1];
    old_word_s  = mem[word_s];
    if (addr_r[0]) begin
      merged_s = {data_r, old_word_s[7:0]};
    end else begin
      merged_s = {old_word_s[15:8], data_r};
    end
    if (cmd_r) begin
      rdata_s = merged_s;
    end else begin
      rdata_s = old_word_s;
    end
  end

  // Store write; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (do_access_s && cmd_r) begin
      mem[word_s] <= merged_s;
    end
  end

  // Transaction FSM, arm tracking and registered port outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r            <= IDLE;
      count_r            <= '0;
      last_grant_r       <= 1'b1;
      grant_r            <= 1'b0;
      cmd_r              <= 1'b0;
      data_r             <= 8'h00;
      addr_r             <= 16'h0000;
      armed_0_r          <= 1'b1;
      armed_1_r          <= 1'b1;
      response_0_r       <= 16'h0000;
      response_ready_0_r <= 1'b0;
      inv_address_0_r    <= 16'h0000;
      inv_valid_0_r      <= 1'b0;
      response_1_r       <= 16'h0000;
      response_ready_1_r <= 1'b0;
      inv_address_1_r    <= 16'h0000;
      inv_valid_1_r      <= 1'b0;
    end else begin
      response_ready_0_r <= 1'b0;
      response_ready_1_r <= 1'b0;
      inv_valid_0_r      <= 1'b0;
      inv_valid_1_r      <= 1'b0;

      // A port re-arms only after it has been seen with ready low
      if (capture_s && !next_grant_s) begin
        armed_0_r <= 1'b0;
      end else if (!port_0.memory_request_ready) begin
        armed_0_r <= 1'b1;
      end
      if (capture_s && next_grant_s) begin
        armed_1_r <= 1'b0;
      end else if (!port_1.memory_request_ready) begin
        armed_1_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (capture_s) begin
            if (next_grant_s) begin
              cmd_r  <= port_1.memory_request[24];
              data_r <= port_1.memory_request[23:16];
              addr_r <= port_1.memory_request[15:0];
            end else begin
              cmd_r  <= port_0.memory_request[24];
              data_r <= port_0.memory_request[23:16];
              addr_r <= port_0.memory_request[15:0];
            end
            count_r      <= CW'(LATENCY - 1);
            last_grant_r <= next_grant_s;
            grant_r      <= next_grant_s;
            state_r      <= ACCESS;
          end
        end
        ACCESS: begin
          if (count_r != '0) begin
            count_r <= count_r - CW'(1);
          end else begin
            state_r <= RESPOND;
            if (grant_r) begin
              response_1_r       <= rdata_s;
              response_ready_1_r <= 1'b1;
              if (cmd_r) begin
                inv_valid_0_r   <= 1'b1;
                inv_address_0_r <= addr_r;
              end
            end else begin
              response_0_r       <= rdata_s;
              response_ready_0_r <= 1'b1;
              if (cmd_r) begin
                inv_valid_1_r   <= 1'b1;
                inv_address_1_r <= addr_r;
              end
            end
          end
        end
        RESPOND: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_r != IDLE);

  assign port_0.memory_response       = response_0_r;
  assign port_0.memory_response_ready = response_ready_0_r;
  assign port_0.invalidate_address    = inv_address_0_r;
  assign port_0.invalidate_valid      = inv_valid_0_r;
  assign port_1.memory_response       = response_1_r;
  assign port_1.memory_response_ready = response_ready_1_r;
  assign port_1.invalidate_address    = inv_address_1_r;
  assign port_1.invalidate_valid      = inv_valid_1_r;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance at LATENCY=2 and one at
// LATENCY=1, with hand-computed expected words, latencies and strobes.
module tb_memory_responder;
  logic clk;
  logic rst;
  logic busy_a;
  logic busy_b;

  int checks;
  int errors;
  int pulses;
  int n_b;
  logic [15:0] saved;

  memory_responder_if a0();
  memory_responder_if a1();
  memory_responder_if b0();
  memory_responder_if b1();

  memory_responder #(.MEM_WORD_BITS(15), .LATENCY(2)) dut_a (
    .clock(clk), .reset(rst), .port_0(a0), .port_1(a1), .busy(busy_a)
  );

  memory_responder #(.MEM_WORD_BITS(15), .LATENCY(1)) dut_b (
    .clock(clk), .reset(rst), .port_0(b0), .port_1(b1), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [24:0] wr(input logic [7:0] d, input logic [15:0] a);
    return {1'b1, d, a};
  endfunction

  function automatic logic [24:0] rd(input logic [15:0] a);
    return {1'b0, 8'h00, a};
  endfunction

  task automatic set_req(input int p, input logic [24:0] req);
    if (p == 0) begin
      a0.memory_request = req;
      a0.memory_request_ready = 1'b1;
    end else begin
      a1.memory_request = req;
      a1.memory_request_ready = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) a0.memory_request_ready = 1'b0;
    else a1.memory_request_ready = 1'b0;
    tick();
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? a0.memory_response_ready : a1.memory_response_ready;
  endfunction

  // Ticks until port p responds (bounded) and checks the cycle count
  task automatic wait_rdy(input int p, input int exp_n, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rdy(p) && n < 8);
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a0.memory_request = 25'h0; a0.memory_request_ready = 1'b0;
    a1.memory_request = 25'h0; a1.memory_request_ready = 1'b0;
    b0.memory_request = 25'h0; b0.memory_request_ready = 1'b0;
    b1.memory_request = 25'h0; b1.memory_request_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_rdy0", 32'(a0.memory_response_ready), 32'h0);
    check("rst_rdy1", 32'(a1.memory_response_ready), 32'h0);
    check("rst_inv1", 32'(a1.invalidate_valid), 32'h0);
    check("rst_resp0", 32'(a0.memory_response), 32'h0);
    check("rst_inva1", 32'(a1.invalidate_address), 32'h0);
    rst = 1'b0;
    tick();

    // Write low byte, then high byte, then read back
    set_req(0, wr(8'hAB, 16'h0010));
    wait_rdy(0, 3, "lat_wr_lo");
    check("wr_lo_byte", 32'(a0.memory_response[7:0]), 32'hAB);
    check("wr_lo_inv1", 32'(a1.invalidate_valid), 32'h1);
    check("wr_lo_inva1", 32'(a1.invalidate_address), 32'h0010);
    check("wr_lo_inv0", 32'(a0.invalidate_valid), 32'h0);
    check("wr_lo_rdy1", 32'(a1.memory_response_ready), 32'h0);
    check("wr_lo_busy", 32'(busy_a), 32'h1);
    drop(0);
    check("after_rdy0", 32'(a0.memory_response_ready), 32'h0);
    check("after_inv1", 32'(a1.invalidate_valid), 32'h0);
    check("after_busy", 32'(busy_a), 32'h0);
    check("hold_resp0", 32'(a0.memory_response[7:0]), 32'hAB);
    check("hold_inva1", 32'(a1.invalidate_address), 32'h0010);

    set_req(0, wr(8'hCD, 16'h0011));
    wait_rdy(0, 3, "lat_wr_hi");
    check("wr_hi_word", 32'(a0.memory_response), 32'hCDAB);
    check("wr_hi_inva1", 32'(a1.invalidate_address), 32'h0011);
    drop(0);

    set_req(0, rd(16'h0010));
    wait_rdy(0, 3, "lat_rd");
    check("rd_word", 32'(a0.memory_response), 32'hCDAB);
    check("rd_no_inv1", 32'(a1.invalidate_valid), 32'h0);
    drop(0);

    // Fresh reset so the first tie goes to port 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    set_req(0, rd(16'h0010));
    set_req(1, rd(16'h0011));
    wait_rdy(0, 3, "tie1_p0_lat");
    check("tie1_p1_wait", 32'(a1.memory_response_ready), 32'h0);
    check("tie1_p0_word", 32'(a0.memory_response), 32'hCDAB);
    drop(0);
    wait_rdy(1, 3, "tie1_p1_lat");
    check("tie1_p1_word", 32'(a1.memory_response), 32'hCDAB);
    drop(1);

    set_req(0, rd(16'h0011));
    wait_rdy(0, 3, "solo_p0_lat");
    drop(0);

    set_req(0, rd(16'h0010));
    set_req(1, rd(16'h0010));
    wait_rdy(1, 3, "tie2_p1_lat");
    check("tie2_p0_wait", 32'(a0.memory_response_ready), 32'h0);
    drop(1);
    wait_rdy(0, 3, "tie2_p0_lat");
    drop(0);

    // Held ready must not produce a second response
    set_req(0, rd(16'h0010));
    wait_rdy(0, 3, "held_lat");
    pulses = 0;
    repeat (3) begin
      tick();
      if (a0.memory_response_ready) pulses++;
    end
    check("held_single", 32'(pulses), 32'h0);
    check("held_idle", 32'(busy_a), 32'h0);
    a0.memory_request_ready = 1'b0;
    tick();
    a0.memory_request_ready = 1'b1;
    wait_rdy(0, 3, "rearm_lat");
    check("rearm_word", 32'(a0.memory_response), 32'hCDAB);
    drop(0);

    // Port 1 write invalidates port 0's copy
    set_req(1, wr(8'h5A, 16'h0200));
    wait_rdy(1, 3, "x_wr_lat");
    check("x_inv0", 32'(a0.invalidate_valid), 32'h1);
    check("x_inva0", 32'(a0.invalidate_address), 32'h0200);
    check("x_no_inv1", 32'(a1.invalidate_valid), 32'h0);
    check("x_wr_byte", 32'(a1.memory_response[7:0]), 32'h5A);
    drop(1);
    set_req(0, rd(16'h0200));
    wait_rdy(0, 3, "x_rd_lat");
    check("x_rd_byte", 32'(a0.memory_response[7:0]), 32'h5A);
    drop(0);

    // Reset during ACCESS aborts the write
    set_req(0, wr(8'h22, 16'h0030));
    wait_rdy(0, 3, "pre_lo_lat");
    drop(0);
    set_req(0, wr(8'h11, 16'h0031));
    wait_rdy(0, 3, "pre_hi_lat");
    check("pre_word", 32'(a0.memory_response), 32'h1122);
    drop(0);
    set_req(0, wr(8'h77, 16'h0030));
    tick();
    check("abort_busy_pre", 32'(busy_a), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_a), 32'h0);
    check("abort_resp0", 32'(a0.memory_response), 32'h0);
    check("abort_inva1", 32'(a1.invalidate_address), 32'h0);
    a0.memory_request_ready = 1'b0;
    tick();
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick();
      if (a0.memory_response_ready || a1.invalidate_valid) pulses++;
    end
    check("abort_no_resp", 32'(pulses), 32'h0);
    set_req(0, rd(16'h0030));
    wait_rdy(0, 3, "abort_rd_lat");
    check("abort_rd_word", 32'(a0.memory_response), 32'h1122);
    drop(0);

    // LATENCY=1 instance: top address, upper byte
    b0.memory_request = wr(8'hEE, 16'hFFFF);
    b0.memory_request_ready = 1'b1;
    n_b = 0;
    do begin
      tick();
      n_b++;
    end while (!b0.memory_response_ready && n_b < 8);
    check("l1_wr_lat", 32'(n_b), 32'h2);
    check("l1_wr_hi", 32'(b0.memory_response[15:8]), 32'hEE);
    check("l1_inv1", 32'(b1.invalidate_valid), 32'h1);
    check("l1_inva1", 32'(b1.invalidate_address), 32'hFFFF);
    saved = b0.memory_response;
    b0.memory_request_ready = 1'b0;
    tick();
    b0.memory_request = rd(16'hFFFE);
    b0.memory_request_ready = 1'b1;
    n_b = 0;
    do begin
      tick();
      n_b++;
    end while (!b0.memory_response_ready && n_b < 8);
    check("l1_rd_lat", 32'(n_b), 32'h2);
    check("l1_rd_hi", 32'(b0.memory_response[15:8]), 32'hEE);
    check("l1_rd_same", 32'(b0.memory_response), 32'(saved));
    b0.memory_request_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
